game_master_fsm_param: RTL and testbench

Parametrised game master FSM for the shooter game in the 2_graphics labs. It sequences rounds and drives the write_xy/write_dxy/enable_update strobes of N target sprites, one bullet and one spaceship. It tracks per-target hits, score, lives and heart visibility, and declares win or loss. It sits between the sprite engines, the collision detectors and the end-of-game timer in the top-level game module.

---
 rtl/game_master_pkg.sv | 30 +++
 rtl/game_master_key_edge.sv | 22 ++
 rtl/game_master_fsm_param.sv | 233 +++++++++++++++++++++++
 tb/tb_game_master_fsm_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_master_pkg.sv
// Shared definitions for the shooter game master: state encoding (also used by
// the debug display) and a small popcount helper for scoring multi-target hits.
package game_master_pkg;

    localparam logic [2:0] ST_START_GAME  = 3'd0;
    localparam logic [2:0] ST_START_ROUND = 3'd1;
    localparam logic [2:0] ST_AIM         = 3'd2;
    localparam logic [2:0] ST_SHOOT       = 3'd3;
    localparam logic [2:0] ST_END_ROUND   = 3'd4;
    localparam logic [2:0] ST_END_GAME    = 3'd5;

    typedef enum logic [2:0] {
        START_GAME  = ST_START_GAME,
        START_ROUND = ST_START_ROUND,
        AIM         = ST_AIM,
        SHOOT       = ST_SHOOT,
        END_ROUND   = ST_END_ROUND,
        END_GAME    = ST_END_GAME
    } game_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/game_master_key_edge.sv
// Rising-edge detector for the launch key; the history register resets to 1 so a
// key held down through reset is not mistaken for a fresh press.
module game_master_key_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic fire_o
);

    logic key_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key_i;
        end
    end

    assign fire_o = key_i & ~key_q;

endmodule

// File: rtl/game_master_fsm_param.sv
// Game master for the shooter game: sequences rounds, drives sprite strobes, and
// keeps score/lives. Define GAME_MASTER_TIMER_EN to enable the end-of-game timer.
module game_master_fsm_param
    import game_master_pkg::*;
#(
    parameter  int N_TARGETS = 3,
    parameter  int MAX_LIVES = 3,
    parameter  int WIN_SCORE = 3,
    localparam int SW        = $clog2(WIN_SCORE + 1),
    localparam int LW        = $clog2(MAX_LIVES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 launch_key_i,
    input  logic [N_TARGETS-1:0] target_within_screen_i,
    input  logic                 bullet_within_screen_i,
    input  logic                 spaceship_within_screen_i,
    input  logic                 collision_i,
    input  logic [N_TARGETS-1:0] collision_bullet_i,
    input  logic                 end_of_game_timer_running_i,
    output logic [N_TARGETS-1:0] target_write_xy_o,
    output logic [N_TARGETS-1:0] target_write_dxy_o,
    output logic [N_TARGETS-1:0] target_enable_update_o,
    output logic                 bullet_write_xy_o,
    output logic                 bullet_write_dxy_o,
    output logic                 bullet_enable_update_o,
    output logic                 spaceship_write_xy_o,
    output logic                 spaceship_write_dxy_o,
    output logic                 spaceship_enable_update_o,
    output logic [MAX_LIVES-1:0] heart_visible_o,
    output logic                 end_of_game_timer_start_o,
    output logic                 game_won_o,
    output logic                 game_over_o,
    output logic [SW-1:0]        score_o,
    output logic [LW-1:0]        n_lives_o,
    output logic [2:0]           state_dbg_o
);

    localparam logic [SW-1:0] WIN_S      = SW'(WIN_SCORE);
    localparam logic [LW-1:0] LIVES_INIT = LW'(MAX_LIVES);

    game_state_e          state_q;
    logic                 shoot_first_q;
    logic [N_TARGETS-1:0] alive_q;
    logic [SW-1:0]        score_q;
    logic [LW-1:0]        lives_q;
    logic [MAX_LIVES-1:0] heart_q;
    logic                 won_q;
    logic                 over_q;
    logic [N_TARGETS-1:0] t_wxy_q;
    logic [N_TARGETS-1:0] t_wdxy_q;
    logic [N_TARGETS-1:0] t_en_q;
    logic                 b_wxy_q;
    logic                 b_wdxy_q;
    logic                 b_en_q;
    logic                 s_wxy_q;
    logic                 s_wdxy_q;
    logic                 s_en_q;
    logic                 timer_start_q;

    logic                 fire;
    logic [N_TARGETS-1:0] hit_d;
    logic [3:0]           hit_cnt_d;
    logic [SW+3:0]        score_sum_d;
    logic [SW-1:0]        score_sat_d;
    logic [LW-1:0]        lives_dec_d;
    logic                 alive_off_d;
    logic [N_TARGETS-1:0] round_mask_d;
    logic                 timer_expired_d;
    logic                 timer_pulse_d;

    game_master_key_edge u_key_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .key_i  (launch_key_i),
        .fire_o (fire)
    );

`ifdef GAME_MASTER_TIMER_EN
    assign timer_expired_d = ~end_of_game_timer_running_i;
    assign timer_pulse_d   = 1'b1;
`else
    logic timer_running_unused;
    assign timer_running_unused = end_of_game_timer_running_i;
    assign timer_expired_d      = 1'b0;
    assign timer_pulse_d        = 1'b0;
`endif

    function automatic logic [MAX_LIVES-1:0] hearts_for(input logic [LW-1:0] n);
        logic [MAX_LIVES-1:0] h;
        for (int k = 0; k < MAX_LIVES; k++) begin
            h[k] = (int'(n) > k);
        end
        return h;
    endfunction

    // Scoring saturates at the win score even if several targets fall at once.
    assign hit_d        = collision_bullet_i & alive_q;
    assign hit_cnt_d    = popcount8(8'(hit_d));
    assign score_sum_d  = (SW+4)'(score_q) + (SW+4)'(hit_cnt_d);
    assign score_sat_d  = (score_sum_d >= (SW+4)'(WIN_SCORE)) ? WIN_S : score_sum_d[SW-1:0];
    assign lives_dec_d  = (lives_q == '0) ? '0 : lives_q - 1'b1;
    assign alive_off_d  = |(alive_q & ~target_within_screen_i);
    assign round_mask_d = (alive_q == '0) ? '1 : alive_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= START_GAME;
            shoot_first_q <= 1'b0;
            alive_q       <= '1;
            score_q       <= '0;
            lives_q       <= LIVES_INIT;
            heart_q       <= '1;
            won_q         <= 1'b0;
            over_q        <= 1'b0;
            t_wxy_q       <= '0;
            t_wdxy_q      <= '0;
            t_en_q        <= '0;
            b_wxy_q       <= 1'b0;
            b_wdxy_q      <= 1'b0;
            b_en_q        <= 1'b0;
            s_wxy_q       <= 1'b0;
            s_wdxy_q      <= 1'b0;
            s_en_q        <= 1'b0;
            timer_start_q <= 1'b0;
        end else begin
            t_wxy_q       <= '0;
            t_wdxy_q      <= '0;
            t_en_q        <= '0;
            b_wxy_q       <= 1'b0;
            b_wdxy_q      <= 1'b0;
            b_en_q        <= 1'b0;
            s_wxy_q       <= 1'b0;
            s_wdxy_q      <= 1'b0;
            s_en_q        <= 1'b0;
            timer_start_q <= 1'b0;
            shoot_first_q <= 1'b0;
            case (state_q)
                START_GAME: begin
                    score_q       <= '0;
                    lives_q       <= LIVES_INIT;
                    heart_q       <= '1;
                    alive_q       <= '1;
                    won_q         <= 1'b0;
                    over_q        <= 1'b0;
                    timer_start_q <= timer_pulse_d;
                    state_q       <= START_ROUND;
                end
                START_ROUND: begin
                    alive_q  <= round_mask_d;
                    t_wxy_q  <= round_mask_d;
                    t_wdxy_q <= round_mask_d;
                    b_wxy_q  <= 1'b1;
                    s_wxy_q  <= 1'b1;
                    state_q  <= AIM;
                end
                AIM: begin
                    t_en_q <= alive_q;
                    if (timer_expired_d) begin
                        over_q  <= 1'b1;
                        state_q <= END_GAME;
                    end else if (collision_i) begin
                        lives_q <= lives_dec_d;
                        heart_q <= hearts_for(lives_dec_d);
                        state_q <= END_ROUND;
                    end else if (fire) begin
                        shoot_first_q <= 1'b1;
                        state_q       <= SHOOT;
                    end else if (alive_off_d || !spaceship_within_screen_i) begin
                        state_q <= END_ROUND;
                    end
                end
                SHOOT: begin
                    t_en_q   <= alive_q;
                    b_en_q   <= 1'b1;
                    s_en_q   <= 1'b1;
                    b_wdxy_q <= shoot_first_q;
                    s_wdxy_q <= shoot_first_q;
                    if (timer_expired_d) begin
                        over_q  <= 1'b1;
                        state_q <= END_GAME;
                    end else if (collision_i) begin
                        lives_q <= lives_dec_d;
                        heart_q <= hearts_for(lives_dec_d);
                        state_q <= END_ROUND;
                    end else if (hit_d != '0) begin
                        score_q <= score_sat_d;
                        alive_q <= alive_q & ~hit_d;
                        state_q <= END_ROUND;
                    end else if (!bullet_within_screen_i || alive_off_d ||
                                 !spaceship_within_screen_i) begin
                        state_q <= END_ROUND;
                    end
                end
                END_ROUND: begin
                    if (score_q == WIN_S) begin
                        won_q   <= 1'b1;
                        state_q <= END_GAME;
                    end else if (lives_q == '0) begin
                        over_q  <= 1'b1;
                        state_q <= END_GAME;
                    end else begin
                        state_q <= START_ROUND;
                    end
                end
                END_GAME: begin
                    if (fire) begin
                        state_q <= START_GAME;
                    end
                end
                default: state_q <= START_GAME;
            endcase
        end
    end

    assign target_write_xy_o         = t_wxy_q;
    assign target_write_dxy_o        = t_wdxy_q;
    assign target_enable_update_o    = t_en_q;
    assign bullet_write_xy_o         = b_wxy_q;
    assign bullet_write_dxy_o        = b_wdxy_q;
    assign bullet_enable_update_o    = b_en_q;
    assign spaceship_write_xy_o      = s_wxy_q;
    assign spaceship_write_dxy_o     = s_wdxy_q;
    assign spaceship_enable_update_o = s_en_q;
    assign heart_visible_o           = heart_q;
    assign end_of_game_timer_start_o = timer_start_q;
    assign game_won_o                = won_q;
    assign game_over_o               = over_q;
    assign score_o                   = score_q;
    assign n_lives_o                 = lives_q;
    assign state_dbg_o               = state_q;

endmodule

// File: tb/tb_game_master_fsm_param.sv
// Scoreboard bench for game_master_fsm_param: directed game scenarios followed by
// random play, every cycle predicted by a rule-level game model.
module tb_game_master_fsm_param;

    localparam int NT = 4;
    localparam int ML = 3;
    localparam int WS = 3;
    localparam int SW = $clog2(WS + 1);
    localparam int LW = $clog2(ML + 1);
`ifdef GAME_MASTER_TIMER_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    localparam int P_START_GAME  = 0;
    localparam int P_START_ROUND = 1;
    localparam int P_AIM         = 2;
    localparam int P_SHOOT       = 3;
    localparam int P_END_ROUND   = 4;
    localparam int P_END_GAME    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, key, bws, sws, col, run;
    logic [NT-1:0] tws, cb;
    logic [NT-1:0] t_wxy, t_wdxy, t_en;
    logic          b_wxy, b_wdxy, b_en, s_wxy, s_wdxy, s_en;
    logic [ML-1:0] heart;
    logic          tstart, won, over;
    logic [SW-1:0] score;
    logic [LW-1:0] lives;
    logic [2:0]    st;

    game_master_fsm_param #(.N_TARGETS(NT), .MAX_LIVES(ML), .WIN_SCORE(WS)) dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .launch_key_i                (key),
        .target_within_screen_i      (tws),
        .bullet_within_screen_i      (bws),
        .spaceship_within_screen_i   (sws),
        .collision_i                 (col),
        .collision_bullet_i          (cb),
        .end_of_game_timer_running_i (run),
        .target_write_xy_o           (t_wxy),
        .target_write_dxy_o          (t_wdxy),
        .target_enable_update_o      (t_en),
        .bullet_write_xy_o           (b_wxy),
        .bullet_write_dxy_o          (b_wdxy),
        .bullet_enable_update_o      (b_en),
        .spaceship_write_xy_o        (s_wxy),
        .spaceship_write_dxy_o       (s_wdxy),
        .spaceship_enable_update_o   (s_en),
        .heart_visible_o             (heart),
        .end_of_game_timer_start_o   (tstart),
        .game_won_o                  (won),
        .game_over_o                 (over),
        .score_o                     (score),
        .n_lives_o                   (lives),
        .state_dbg_o                 (st)
    );

    typedef struct {
        int            cyc;
        int            st;
        logic [NT-1:0] twxy, twdxy, ten;
        logic          bwxy, bwdxy, ben, swxy, swdxy, sen, tstart, won, over;
        logic [ML-1:0] heart;
        int            score, lives;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Game model, in terms of the rules of play rather than the circuit.
    int m_phase, m_last_phase, m_score, m_lives;
    bit m_prev_key, m_won, m_over;
    bit m_alive[NT];

    task automatic modelStep();
        exp_t e;
        bit   fire, any_alive, alive_off;
        int   nxt, hits;
        e = '{default: 0};
        e.cyc = cyc + 1;
        if (rst) begin
            m_phase = P_START_GAME; m_last_phase = P_START_GAME;
            m_prev_key = 1'b1; m_score = 0; m_lives = ML; m_won = 0; m_over = 0;
            foreach (m_alive[i]) m_alive[i] = 1'b1;
        end else begin
            fire = key && !m_prev_key;
            m_prev_key = key;
            nxt = m_phase;
            alive_off = 0; any_alive = 0;
            foreach (m_alive[i]) begin
                if (m_alive[i] && !tws[i]) alive_off = 1;
                if (m_alive[i]) any_alive = 1;
            end
            case (m_phase)
                P_START_GAME: begin
                    m_score = 0; m_lives = ML; m_won = 0; m_over = 0;
                    foreach (m_alive[i]) m_alive[i] = 1'b1;
                    e.tstart = TEN;
                    nxt = P_START_ROUND;
                end
                P_START_ROUND: begin
                    if (!any_alive) foreach (m_alive[i]) m_alive[i] = 1'b1;
                    foreach (m_alive[i]) begin
                        e.twxy[i] = m_alive[i];
                        e.twdxy[i] = m_alive[i];
                    end
                    e.bwxy = 1; e.swxy = 1;
                    nxt = P_AIM;
                end
                P_AIM, P_SHOOT: begin
                    foreach (m_alive[i]) e.ten[i] = m_alive[i];
                    if (m_phase == P_SHOOT) begin
                        e.ben = 1; e.sen = 1;
                        e.bwdxy = (m_last_phase != P_SHOOT);
                        e.swdxy = (m_last_phase != P_SHOOT);
                    end
                    hits = 0;
                    foreach (m_alive[i]) if (m_alive[i] && cb[i]) hits++;
                    if (TEN && !run) begin
                        m_over = 1; nxt = P_END_GAME;
                    end else if (col) begin
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        nxt = P_END_ROUND;
                    end else if (m_phase == P_AIM) begin
                        if (fire) nxt = P_SHOOT;
                        else if (alive_off || !sws) nxt = P_END_ROUND;
                    end else if (hits > 0) begin
                        m_score = (m_score + hits > WS) ? WS : m_score + hits;
                        foreach (m_alive[i]) if (cb[i]) m_alive[i] = 1'b0;
                        nxt = P_END_ROUND;
                    end else if (!bws || alive_off || !sws) begin
                        nxt = P_END_ROUND;
                    end
                end
                P_END_ROUND: begin
                    if (m_score == WS) begin m_won = 1; nxt = P_END_GAME; end
                    else if (m_lives == 0) begin m_over = 1; nxt = P_END_GAME; end
                    else nxt = P_START_ROUND;
                end
                default: if (fire) nxt = P_START_GAME;
            endcase
            m_last_phase = m_phase;
            m_phase = nxt;
        end
        e.st = m_phase; e.score = m_score; e.lives = m_lives;
        e.won = m_won; e.over = m_over;
        for (int k = 0; k < ML; k++) e.heart[k] = (m_lives > k);
        q.push_back(e);
    endtask

    task automatic applyStimulus(input bit r, input bit k, input logic [NT-1:0] t_in,
                                 input bit b_in, input bit s_in, input bit c_in,
                                 input logic [NT-1:0] cb_in, input bit run_in);
        rst = r; key = k; tws = t_in; bws = b_in; sws = s_in;
        col = c_in; cb = cb_in; run = run_in;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit k, input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, k, '1, 1, 1, 0, '0, 1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            checkOutput("state",        32'(st),     32'(mon_e.st));
            checkOutput("target_wxy",   32'(t_wxy),  32'(mon_e.twxy));
            checkOutput("target_wdxy",  32'(t_wdxy), 32'(mon_e.twdxy));
            checkOutput("target_en",    32'(t_en),   32'(mon_e.ten));
            checkOutput("bullet_wxy",   32'(b_wxy),  32'(mon_e.bwxy));
            checkOutput("bullet_wdxy",  32'(b_wdxy), 32'(mon_e.bwdxy));
            checkOutput("bullet_en",    32'(b_en),   32'(mon_e.ben));
            checkOutput("ship_wxy",     32'(s_wxy),  32'(mon_e.swxy));
            checkOutput("ship_wdxy",    32'(s_wdxy), 32'(mon_e.swdxy));
            checkOutput("ship_en",      32'(s_en),   32'(mon_e.sen));
            checkOutput("heart",        32'(heart),  32'(mon_e.heart));
            checkOutput("timer_start",  32'(tstart), 32'(mon_e.tstart));
            checkOutput("game_won",     32'(won),    32'(mon_e.won));
            checkOutput("game_over",    32'(over),   32'(mon_e.over));
            checkOutput("score",        32'(score),  32'(mon_e.score));
            checkOutput("n_lives",      32'(lives),  32'(mon_e.lives));
        end
    end

    initial begin
        logic [NT-1:0] r_tws, r_cb;
        bit            r_key;
        // Key held through reset and afterwards must never fire.
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, '1, 1, 1, 0, '0, 1);
        idle(1, 6);
        // Fire, then hit target 1 only.
        idle(0, 1);
        applyStimulus(0, 1, '1, 1, 1, 0, 4'b0010, 1);
        applyStimulus(0, 1, '1, 1, 1, 0, 4'b0010, 1);
        idle(0, 4);
        // Fire, then hit all remaining targets: score saturates and the game is won.
        applyStimulus(0, 1, '1, 1, 1, 0, 4'b1111, 1);
        applyStimulus(0, 1, '1, 1, 1, 0, 4'b1111, 1);
        idle(1, 6);
        idle(0, 1);
        idle(1, 1);
        idle(0, 4);
        // Collision together with a bullet hit: only a life is lost.
        applyStimulus(0, 1, '1, 1, 1, 0, '0, 1);
        applyStimulus(0, 1, '1, 1, 1, 1, 4'b0001, 1);
        idle(0, 3);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, '1, 1, 1, 1, '0, 1);
        // Restart, fire, then drop the timer while shooting.
        idle(1, 1);
        idle(0, 4);
        applyStimulus(0, 1, '1, 1, 1, 0, '0, 1);
        applyStimulus(0, 1, '1, 1, 1, 0, '0, 0);
        idle(0, 3);
        // Random play with occasional mid-game resets.
        r_key = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) r_key = ~r_key;
            for (int b = 0; b < NT; b++) begin
                r_tws[b] = ($urandom_range(0, 29) != 0);
                r_cb[b]  = ($urandom_range(0, 7) == 0);
            end
            applyStimulus($urandom_range(0, 199) == 0, r_key, r_tws,
                          $urandom_range(0, 14) != 0, $urandom_range(0, 39) != 0,
                          $urandom_range(0, 24) == 0, r_cb, $urandom_range(0, 59) != 0);
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
